// File: rtl/npc_defs.sv
// ============================================================================
// Module   : npc_defs
// Brief    : Shared constants and fetch FSM encoding for the fetch front end.
// Revision : 1.0
// ============================================================================
`default_nettype none

package npc_defs;

    localparam int unsigned     DEF_XLEN     = 32;
    localparam logic [31:0]     DEF_RESET_PC = 32'h8000_0000;
    localparam int unsigned     INSTR_BYTES  = 4;

    localparam logic [1:0]      S_REQ        = 2'd0;
    localparam logic [1:0]      S_WAIT       = 2'd1;
    localparam logic [1:0]      S_HOLD       = 2'd2;

endpackage

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch unit; owns the PC, requests words from imem and
//            hands them to decode. Optional trace output under IFU_TRACE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifu_fetch
    import npc_defs::*;
#(
    parameter int unsigned      XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [XLEN-1:0]     imem_rsp_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_instr,
    output logic [XLEN-1:0]     out_pc,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc
);

    logic [1:0]         state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               kill_q, kill_d;
    logic               req_valid_q, req_valid_d;
    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    out_instr_q, out_instr_d;
    logic [XLEN-1:0]    out_pc_q, out_pc_d;
    logic               w_req_fire;
    logic [XLEN-1:0]    w_redirect_target;

    assign w_req_fire        = req_valid_q & imem_req_ready;
    assign w_redirect_target = redirect_pc & ~(XLEN'(INSTR_BYTES - 1));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        case (state_q)
            S_REQ: begin
                if (w_req_fire) begin
                    state_d = S_WAIT;
                    // The accepted request's response must be discarded.
                    if (redirect_valid) kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        out_instr_d = imem_rsp_data;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_REQ;
                    if (!redirect_valid) pc_d = pc_q + XLEN'(INSTR_BYTES);
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect_valid) pc_d = w_redirect_target;

        req_valid_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            req_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            req_valid_q <= req_valid_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign out_valid      = out_valid_q;
    assign out_instr      = out_instr_q;
    assign out_pc         = out_pc_q;

`ifndef SYNTHESIS
    // Memory may only answer while a request is outstanding.
    always @(posedge clk) begin
        if (!rst && imem_rsp_valid) begin
            assert (state_q == S_WAIT);
        end
    end
`endif

`ifdef IFU_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid_q && out_ready)
                $display("ifu_fetch: issue pc=%h instr=%h", out_pc_q, out_instr_q);
            if (redirect_valid)
                $display("ifu_fetch: redirect pc %h -> %h", pc_q, w_redirect_target);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module   : tb_ifu_fetch
// Brief    : Scoreboard bench for ifu_fetch with a latency-configurable memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } out_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default reset PC)
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Wrap instance (reset PC at top of address space)
    logic        rst2;
    logic        req_valid2, req_ready2;
    logic [31:0] req_addr2;
    logic        rsp_valid2;
    logic [31:0] rsp_data2;
    logic        out_valid2, out_ready2;
    logic [31:0] out_instr2, out_pc2;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;

    ifu_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    ifu_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2),
        .imem_req_valid(req_valid2), .imem_req_ready(req_ready2),
        .imem_req_addr(req_addr2),
        .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_instr(out_instr2), .out_pc(out_pc2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat;
    logic        mem_ready;
    logic        gap_en;
    logic [31:0] exp_req[$];
    out_t        exp_out[$];
    logic [31:0] exp_req2[$];
    out_t        exp_out2[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h8000_000C) return 32'h0050_0093;
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic out_t mk(input logic [31:0] pc);
        out_t o;
        o.pc    = pc;
        o.instr = word(pc);
        return o;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    // Memory model: single outstanding request, response after lat cycles.
    initial begin : mem1
        logic        fire;
        logic [31:0] a, pa;
        bit          pend;
        int          cnt;
        pend = 0; cnt = 0; pa = '0;
        forever begin
            @(negedge clk);
            fire = imem_req_valid && imem_req_ready;
            a    = imem_req_addr;
            @(posedge clk); #1;
            imem_rsp_valid = 1'b0;
            imem_req_ready = mem_ready;
            if (rst) begin
                pend = 0;
            end else begin
                if (fire) begin pend = 1; cnt = lat; pa = a; end
                if (pend) begin
                    cnt--;
                    if (cnt <= 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = word(pa);
                        pend = 0;
                    end
                end
            end
        end
    end

    initial begin : mem2
        logic        f2;
        logic [31:0] a2;
        forever begin
            @(negedge clk);
            f2 = req_valid2 && req_ready2;
            a2 = req_addr2;
            @(posedge clk); #1;
            rsp_valid2 = f2 && !rst2;
            rsp_data2  = word(a2);
        end
    end

    // Monitor: requests and output handshakes checked against the scoreboard.
    logic        hold_prev = 1'b0;
    logic [31:0] prev_pc, prev_instr;
    int          last_hs = -1;

    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            if (exp_req.size() == 0) fail_now("req_unexpected");
            else check("req_addr", imem_req_addr, exp_req.pop_front());
        end
        if (!rst && hold_prev) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_pc", out_pc, prev_pc);
            check("hold_instr", out_instr, prev_instr);
        end
        if (!rst && out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
                fail_now("out_unexpected");
            end else begin
                out_t e;
                e = exp_out.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_instr", out_instr, e.instr);
            end
            if (gap_en && last_hs >= 0) check("issue_gap", 32'(cyc - last_hs), 32'd3);
            last_hs = cyc;
        end
        hold_prev  = !rst && out_valid && !out_ready && !redirect_valid;
        prev_pc    = out_pc;
        prev_instr = out_instr;

        if (!rst2 && req_valid2 && req_ready2) begin
            if (exp_req2.size() == 0) fail_now("wrap_req_unexpected");
            else check("wrap_req_addr", req_addr2, exp_req2.pop_front());
        end
        if (!rst2 && out_valid2 && out_ready2) begin
            if (exp_out2.size() == 0) begin
                fail_now("wrap_out_unexpected");
            end else begin
                out_t e2;
                e2 = exp_out2.pop_front();
                check("wrap_out_pc", out_pc2, e2.pc);
                check("wrap_out_instr", out_instr2, e2.instr);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    function automatic bit sig(input int which);
        case (which)
            0:       return out_valid;
            1:       return imem_req_valid;
            2:       return imem_rsp_valid;
            3:       return exp_out.size() == 0;
            default: return exp_out2.size() == 0;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int which);
        int n;
        n = 0;
        while (!sig(which) && n < 60) begin tick(); n++; end
        if (!sig(which)) begin
            checks++;
            errors++;
            $display("FAIL %s: got timeout expected event", nm);
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        out_ready = 1'b1; out_ready2 = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        redirect_valid2 = 1'b0; redirect_pc2 = '0;
        mem_ready = 1'b1; lat = 1; gap_en = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        req_ready2 = 1'b1; rsp_valid2 = 1'b0; rsp_data2 = '0;
        repeat (3) tick();

        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_wrap_out_valid", {31'd0, out_valid2}, 32'd0);

        // Zero-wait streaming, then backpressure on the fourth word
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back(32'h8000_0000 + 32'(4 * i));
            exp_out.push_back(mk(32'h8000_0000 + 32'(4 * i)));
        end
        gap_en = 1'b1;
        rst = 1'b0;
        while (exp_out.size() > 1 && cyc < 200) tick();
        out_ready = 1'b0;
        gap_en = 1'b0;
        wait_for("bp_out_valid", 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_no_req", {31'd0, imem_req_valid}, 32'd0);
            check("bp_instr", out_instr, 32'h0050_0093);
            tick();
        end
        lat = 3;
        exp_req.push_back(32'h8000_0010);
        out_ready = 1'b1;
        tick();

        // Redirect while waiting on a slow response
        exp_req.push_back(32'h8000_0100);
        exp_out.push_back(mk(32'h8000_0100));
        wait_for("wait_req_0x10", 1);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
        tick();
        redirect_valid = 1'b0; lat = 1;

        // Redirect in HOLD coincident with the output handshake
        wait_for("hold_out_valid", 0);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        exp_req.push_back(32'h8000_0200);
        tick();
        redirect_valid = 1'b0;

        // Redirect coincident with request accept
        wait_for("req_0x200", 1);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        exp_req.push_back(32'h8000_0300);
        tick();
        redirect_valid = 1'b0;

        // Redirect coincident with the response
        wait_for("req_0x300", 1);
        tick();
        wait_for("rsp_0x300", 2);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0407;
        exp_req.push_back(32'h8000_0404);
        exp_out.push_back(mk(32'h8000_0404));
        tick();
        redirect_valid = 1'b0;

        // Redirect in S_REQ while memory is stalled
        wait_for("out_0x404", 0);
        mem_ready = 1'b0;
        tick();
        check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("stall_req_addr", imem_req_addr, 32'h8000_0408);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0500;
        exp_req.push_back(32'h8000_0500);
        exp_out.push_back(mk(32'h8000_0500));
        tick();
        redirect_valid = 1'b0;
        check("stall_redir_addr", imem_req_addr, 32'h8000_0500);
        mem_ready = 1'b1;

        // Reset mid-S_WAIT
        wait_for("out_0x500", 0);
        lat = 3;
        exp_req.push_back(32'h8000_0504);
        tick();
        wait_for("req_0x504", 1);
        tick();
        rst = 1'b1;
        exp_req.push_back(32'h8000_0000);
        exp_out.push_back(mk(32'h8000_0000));
        tick();
        rst = 1'b0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("midrst_pc", imem_req_addr, 32'h8000_0000);
        wait_for("post_rst_out", 0);
        mem_ready = 1'b0;
        tick(); tick();
        check("req_queue_empty", 32'(exp_req.size()), 32'd0);
        check("out_queue_empty", 32'(exp_out.size()), 32'd0);

        // PC wrap on the second instance
        exp_req2.push_back(32'hFFFF_FFFC);
        exp_req2.push_back(32'h0000_0000);
        exp_req2.push_back(32'h0000_0004);
        exp_out2.push_back(mk(32'hFFFF_FFFC));
        exp_out2.push_back(mk(32'h0000_0000));
        rst2 = 1'b0;
        wait_for("wrap_drain", 4);
        out_ready2 = 1'b0;
        repeat (4) tick();
        check("wrap_req_queue_empty", 32'(exp_req2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
